disp_source_sched: RTL and testbench

Scheduler that shares the 8-digit seven-segment display between four 32-bit debug sources, such as PC, instruction, ALU result and a register value. It debounces two front-panel buttons, sequences source selection manually or by timed auto-rotation, and supports freezing a snapshot. It drives the 33-bit display data bus of the display scan driver:
- bits 32:1 carry eight hex digits, MSB digit first.
- bit 0 is the active-low decimal-point bit, applied to all digits.

---
 rtl/disp_source_sched.sv | 143 ++++++++++++++
 tb/tb_disp_source_sched.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/disp_source_sched.sv
// Shares the 8-digit seven-segment display between four 32-bit debug sources.
// Optional timed auto-rotation is built only when DISP_SCHED_AUTO_EN is defined.

module disp_sched_debounce #(
  parameter int W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic [1:0]   sync_q;
  logic         stable;
  logic         stable_d;
  logic [W-1:0] cnt;

  // The raw button is asynchronous, so it is double-registered before the
  // debounce counter looks at it; stable only flips after 2^W disagreeing cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 2'b00;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      sync_q   <= {sync_q[0], btn};
      stable_d <= stable;
      if (sync_q[1] != stable) begin
        if (&cnt) begin
          stable <= sync_q[1];
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign pulse = stable & ~stable_d;

endmodule

module disp_source_sched #(
  parameter int DEBOUNCE_W = 16,
  parameter int DWELL_W    = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] src0,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [31:0] src3,
  input  logic        btn_next,
  input  logic        btn_freeze,
  input  logic        auto_mode,
  output logic [32:0] data,
  output logic [1:0]  sel,
  output logic        frozen,
  output logic        advance
);

  logic        nxt_p;
  logic        frz_p;
  logic        expiry;
  logic        do_adv;
  logic [31:0] live;
  logic [31:0] hold;

  disp_sched_debounce #(.W(DEBOUNCE_W)) u_deb_next (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_next),
    .pulse (nxt_p)
  );

  disp_sched_debounce #(.W(DEBOUNCE_W)) u_deb_freeze (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_freeze),
    .pulse (frz_p)
  );

`ifdef DISP_SCHED_AUTO_EN
  logic [DWELL_W-1:0] dwell;

  // Any next-press restarts the dwell so a manual advance gets a full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell <= '0;
    end else if (!auto_mode || frozen || nxt_p) begin
      dwell <= '0;
    end else begin
      dwell <= dwell + 1'b1;
    end
  end

  assign expiry = auto_mode & ~frozen & (&dwell);
`else
  logic unused_auto;
  assign unused_auto = auto_mode;
  assign expiry      = 1'b0;
`endif

  // A freeze toggle wins over a simultaneous next-press, which is dropped.
  assign do_adv = (nxt_p & ~frozen & ~frz_p) | expiry;

  always_comb begin
    live = src0;
    case (sel)
      2'd0: live = src0;
      2'd1: live = src1;
      2'd2: live = src2;
      2'd3: live = src3;
      default: live = src0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel     <= 2'd0;
      frozen  <= 1'b0;
      hold    <= 32'h0;
      advance <= 1'b0;
      data    <= 33'h0_0000_0001;
    end else begin
      advance <= do_adv;
      if (do_adv) begin
        sel <= sel + 2'd1;
      end
      if (frz_p) begin
        frozen <= ~frozen;
      end
      if (frz_p && !frozen) begin
        hold <= live;
      end
      data <= {frozen ? hold : live, ~frozen};
    end
  end

endmodule

// File: tb/tb_disp_source_sched.sv
// Directed, table-driven bench for disp_source_sched with short debounce/dwell
// counters; the auto-rotation section follows DISP_SCHED_AUTO_EN.

module tb_disp_source_sched;

  logic        clk;
  logic        rst_n;
  logic [31:0] src0, src1, src2, src3;
  logic        btn_next;
  logic        btn_freeze;
  logic        auto_mode;
  logic [32:0] data;
  logic [1:0]  sel;
  logic        frozen;
  logic        advance;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        nxt;
    logic        frz;
    int          len;
    logic [31:0] s2;
    logic [1:0]  esel;
    logic        efrz;
    logic [32:0] edata;
    int          eadv;
  } vec_t;

  vec_t vecs[11];

  disp_source_sched #(.DEBOUNCE_W(3), .DWELL_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src0       (src0),
    .src1       (src1),
    .src2       (src2),
    .src3       (src3),
    .btn_next   (btn_next),
    .btn_freeze (btn_freeze),
    .auto_mode  (auto_mode),
    .data       (data),
    .sel        (sel),
    .frozen     (frozen),
    .advance    (advance)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Holds the buttons for len cycles, releases for rel cycles, counts advance pulses.
  task automatic pressButtons(input logic nxt, input logic frz, input int len,
                              input int rel, output int adv);
    adv = 0;
    btn_next   = nxt;
    btn_freeze = frz;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (advance) adv++;
    end
    btn_next   = 1'b0;
    btn_freeze = 1'b0;
    for (int i = 0; i < rel; i++) begin
      @(negedge clk);
      if (advance) adv++;
    end
  endtask

  task automatic applyStimulus(input int idx);
    int adv;
    src2 = vecs[idx].s2;
    pressButtons(vecs[idx].nxt, vecs[idx].frz, vecs[idx].len, 25, adv);
    checkOutput($sformatf("v%0d_sel", idx), {31'b0, sel}, {31'b0, vecs[idx].esel});
    checkOutput($sformatf("v%0d_frozen", idx), {32'b0, frozen}, {32'b0, vecs[idx].efrz});
    checkOutput($sformatf("v%0d_data", idx), data, vecs[idx].edata);
    checkOutput($sformatf("v%0d_advcount", idx), 33'(adv), 33'(vecs[idx].eadv));
  endtask

  task automatic waitAdvance(input int limit, output int waited, output logic seen);
    seen   = 1'b0;
    waited = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (advance) begin
        seen   = 1'b1;
        waited = i + 1;
      end
    end
  endtask

  initial begin
    int          adv;
    int          w;
    logic        seen;
    logic [1:0]  exp_sel;

    vecs[0]  = '{1'b1, 1'b0, 5,  32'h3333_3333, 2'd0, 1'b0, {32'h1111_1111, 1'b1}, 0};
    vecs[1]  = '{1'b1, 1'b0, 20, 32'h3333_3333, 2'd1, 1'b0, {32'h2222_2222, 1'b1}, 1};
    vecs[2]  = '{1'b1, 1'b0, 20, 32'h3333_3333, 2'd2, 1'b0, {32'h3333_3333, 1'b1}, 1};
    vecs[3]  = '{1'b0, 1'b1, 20, 32'h3333_3333, 2'd2, 1'b1, {32'h3333_3333, 1'b0}, 0};
    vecs[4]  = '{1'b1, 1'b0, 20, 32'hDEAD_BEEF, 2'd2, 1'b1, {32'h3333_3333, 1'b0}, 0};
    vecs[5]  = '{1'b0, 1'b1, 20, 32'hDEAD_BEEF, 2'd2, 1'b0, {32'hDEAD_BEEF, 1'b1}, 0};
    vecs[6]  = '{1'b1, 1'b0, 20, 32'hDEAD_BEEF, 2'd3, 1'b0, {32'h4444_4444, 1'b1}, 1};
    vecs[7]  = '{1'b1, 1'b0, 20, 32'hDEAD_BEEF, 2'd0, 1'b0, {32'h1111_1111, 1'b1}, 1};
    vecs[8]  = '{1'b1, 1'b1, 20, 32'hDEAD_BEEF, 2'd0, 1'b1, {32'h1111_1111, 1'b0}, 0};
    vecs[9]  = '{1'b0, 1'b1, 20, 32'hDEAD_BEEF, 2'd0, 1'b0, {32'h1111_1111, 1'b1}, 0};
    vecs[10] = '{1'b0, 1'b1, 4,  32'hDEAD_BEEF, 2'd0, 1'b0, {32'h1111_1111, 1'b1}, 0};

    src0 = 32'h1111_1111;
    src1 = 32'h2222_2222;
    src2 = 32'h3333_3333;
    src3 = 32'h4444_4444;
    rst_n      = 1'b0;
    btn_next   = 1'b1;
    btn_freeze = 1'b1;
    auto_mode  = 1'b1;

    // Reset held with every input active.
    repeat (20) @(negedge clk);
    checkOutput("rst_sel", {31'b0, sel}, 33'd0);
    checkOutput("rst_frozen", {32'b0, frozen}, 33'd0);
    checkOutput("rst_advance", {32'b0, advance}, 33'd0);
    checkOutput("rst_data", data, 33'h0_0000_0001);
    btn_next   = 1'b0;
    btn_freeze = 1'b0;
    auto_mode  = 1'b0;
    rst_n      = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post_rst_data", data, {32'h1111_1111, 1'b1});
    checkOutput("post_rst_sel", {31'b0, sel}, 33'd0);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(i);
    end

`ifdef DISP_SCHED_AUTO_EN
    // Undisturbed rotation: one advance every 16 cycles, sel 1,2,3,0.
    auto_mode = 1'b1;
    exp_sel = 2'd0;
    for (int k = 0; k < 4; k++) begin
      exp_sel = exp_sel + 2'd1;
      waitAdvance(40, w, seen);
      checkOutput($sformatf("auto%0d_seen", k), {32'b0, seen}, 33'd1);
      checkOutput($sformatf("auto%0d_period", k), 33'(w), 33'd16);
      checkOutput($sformatf("auto%0d_sel", k), {31'b0, sel}, {31'b0, exp_sel});
    end

    // Manual press mid-dwell advances early and restarts the dwell.
    btn_next = 1'b1;
    waitAdvance(15, w, seen);
    checkOutput("manual_seen", {32'b0, seen}, 33'd1);
    checkOutput("manual_early", {32'b0, (w > 0 && w < 16)}, 33'd1);
    checkOutput("manual_sel", {31'b0, sel}, 33'd1);
    w = 0;
    for (int k = 1; k <= 20 && w == 0; k++) begin
      @(negedge clk);
      if (k == 9) btn_next = 1'b0;
      if (advance) w = k;
    end
    btn_next = 1'b0;
    checkOutput("after_manual_period", 33'(w), 33'd16);
    checkOutput("after_manual_sel", {31'b0, sel}, 33'd2);

    // Frozen display blocks auto-rotation.
    auto_mode = 1'b0;
    pressButtons(1'b0, 1'b1, 20, 25, adv);
    checkOutput("auto_freeze_frozen", {32'b0, frozen}, 33'd1);
    auto_mode = 1'b1;
    adv = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (advance) adv++;
    end
    checkOutput("auto_frozen_advcount", 33'(adv), 33'd0);
    checkOutput("auto_frozen_sel", {31'b0, sel}, 33'd2);
    auto_mode = 1'b0;
    pressButtons(1'b0, 1'b1, 20, 25, adv);
    checkOutput("auto_unfreeze_frozen", {32'b0, frozen}, 33'd0);
    checkOutput("auto_unfreeze_data", data, {32'hDEAD_BEEF, 1'b1});
`else
    // Without the auto feature auto_mode must have no effect.
    auto_mode = 1'b1;
    adv = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (advance) adv++;
    end
    auto_mode = 1'b0;
    checkOutput("noauto_advcount", 33'(adv), 33'd0);
    checkOutput("noauto_sel", {31'b0, sel}, 33'd0);
`endif

    // Asynchronous reset must clear outputs without waiting for a clock edge.
    src0 = 32'h1111_1111;
    pressButtons(1'b1, 1'b0, 20, 25, adv);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_sel", {31'b0, sel}, 33'd0);
    checkOutput("async_rst_data", data, 33'h0_0000_0001);
    checkOutput("async_rst_frozen", {32'b0, frozen}, 33'd0);
    checkOutput("async_rst_advance", {32'b0, advance}, 33'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
